// File: rtl/idelay_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : idelay_pkg
//  Description : Shared FSM encoding, tap width and sizing helper for the
//                IDELAY tap scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package idelay_pkg;

    localparam int c_TAP_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_MEASURE = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    // Bits needed to hold the value v, never less than one.
    function automatic int f_width(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage : idelay_pkg
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timer
//  Description : Loadable down-counter that stops at zero and flags it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load wins over decrement so a reload on the expiry cycle is never lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : cycle_timer
`default_nettype wire

// File: rtl/idelay_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : idelay_tap_scheduler
//  Description : Sweeps IDELAY taps, counts comparator errors per tap and
//                reports one (tap, count) result per tap with handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module idelay_tap_scheduler
    import idelay_pkg::*;
#(
    parameter int DELAY_TAPS       = 32,
    parameter int COUNT_WIDTH      = 24,
    parameter int HOLDOFF_TIME     = 100,
    parameter int MEASURE_TIME     = 10000,
    parameter int TRIGGER_INTERVAL = 50000000
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   START,
    input  logic                   I_STB,
    input  logic                   I_ERR,
    output logic                   DLY_LD,
    output logic [5:0]             DLY_CNT,
    output logic                   O_STB,
    input  logic                   O_RDY,
    output logic [c_TAP_W-1:0]     O_TAP,
    output logic [COUNT_WIDTH-1:0] O_CNT,
    output logic                   BUSY,
    output logic                   DONE
);

    localparam int c_PH_MAX = (HOLDOFF_TIME > MEASURE_TIME) ? HOLDOFF_TIME : MEASURE_TIME;
    localparam int c_PH_W   = f_width(c_PH_MAX);
    localparam int c_TRIG_W = f_width(TRIGGER_INTERVAL);

    localparam logic [c_PH_W-1:0]   c_HOLD_LD  = c_PH_W'(HOLDOFF_TIME - 1);
    localparam logic [c_PH_W-1:0]   c_MEAS_LD  = c_PH_W'(MEASURE_TIME - 1);
    localparam logic [c_TRIG_W-1:0] c_TRIG_LD  = (TRIGGER_INTERVAL > 0) ?
                                                 c_TRIG_W'(TRIGGER_INTERVAL - 1) : '0;
    localparam logic [c_TAP_W-1:0]  c_LAST_TAP = c_TAP_W'(DELAY_TAPS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_TAP_W-1:0]       r_tap;
    logic [COUNT_WIDTH-1:0]   r_cnt;
    logic                     r_done;

    logic                     w_ph_load;
    logic [c_PH_W-1:0]        w_ph_val;
    logic                     w_ph_dec;
    logic                     w_ph_zero;
    logic                     w_trig_load;
    logic                     w_trig_dec;
    logic                     w_trig_zero;
    logic                     w_trig_expire;
    logic                     w_tap_inc;
    logic                     w_tap_clr;
    logic                     w_cnt_clr;
    logic                     w_cnt_inc;
    logic                     w_done_nxt;

    // Shared by HOLDOFF and MEASURE; each phase reloads it with its length-1.
    cycle_timer #(
        .WIDTH      (c_PH_W),
        .RST_VAL    ('0)
    ) u_phase_timer (
        .clk        (CLK),
        .rstn       (RSTN),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_dec      (w_ph_dec),
        .o_zero     (w_ph_zero)
    );

    cycle_timer #(
        .WIDTH      (c_TRIG_W),
        .RST_VAL    (c_TRIG_LD)
    ) u_trig_timer (
        .clk        (CLK),
        .rstn       (RSTN),
        .i_load     (w_trig_load),
        .i_load_val (c_TRIG_LD),
        .i_dec      (w_trig_dec),
        .o_zero     (w_trig_zero)
    );

    generate
        if (TRIGGER_INTERVAL > 0) begin : g_trig_on
            assign w_trig_expire = w_trig_zero;
        end else begin : g_trig_off
            assign w_trig_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_load   = 1'b0;
        w_ph_val    = '0;
        w_ph_dec    = 1'b0;
        w_trig_load = 1'b0;
        w_trig_dec  = 1'b0;
        w_tap_inc   = 1'b0;
        w_tap_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_trig_dec = 1'b1;
                if (START || w_trig_expire) begin
                    w_state_nxt = ST_LOAD;
                    w_trig_load = 1'b1;
                    w_tap_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_HOLDOFF;
                w_ph_load   = 1'b1;
                w_ph_val    = c_HOLD_LD;
            end
            ST_HOLDOFF: begin
                if (w_ph_zero) begin
                    w_state_nxt = ST_MEASURE;
                    w_ph_load   = 1'b1;
                    w_ph_val    = c_MEAS_LD;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_ph_dec    = 1'b1;
                end
            end
            ST_MEASURE: begin
                w_cnt_inc = I_STB & I_ERR;
                if (w_ph_zero) begin
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_ph_dec    = 1'b1;
                end
            end
            ST_REPORT: begin
                if (O_RDY) begin
                    if (r_tap == c_LAST_TAP) begin
                        w_state_nxt = ST_IDLE;
                        w_tap_clr   = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_tap_inc   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tap returns to 0 at sweep end so DLY_CNT reads 0 whenever idle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_tap  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_tap_clr) begin
                r_tap <= '0;
            end else if (w_tap_inc) begin
                r_tap <= r_tap + 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc && (r_cnt != {COUNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign DLY_LD  = (r_state == ST_LOAD);
    assign DLY_CNT = {1'b0, r_tap};
    assign O_STB   = (r_state == ST_REPORT);
    assign O_TAP   = r_tap;
    assign O_CNT   = r_cnt;
    assign BUSY    = (r_state != ST_IDLE);
    assign DONE    = r_done;

endmodule : idelay_tap_scheduler
`default_nettype wire

// File: tb/tb_idelay_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idelay_tap_scheduler
//  Description : Directed self-checking bench for idelay_tap_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idelay_tap_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_stb = 1'b0;
    logic i_err = 1'b0;

    // DUT A: 4 taps, H=3, M=8, no auto-trigger
    logic       rstn_a = 1'b0, start_a = 1'b0, rdy_a = 1'b1;
    logic       ld_a, ostb_a, busy_a, done_a;
    logic [5:0] dcnt_a;
    logic [4:0] otap_a;
    logic [7:0] ocnt_a;

    // DUT B: 2 taps, 3-bit count, M=20
    logic       rstn_b = 1'b0, start_b = 1'b0, rdy_b = 1'b1;
    logic       ld_b, ostb_b, busy_b, done_b;
    logic [5:0] dcnt_b;
    logic [4:0] otap_b;
    logic [2:0] ocnt_b;

    // DUT C: 2 taps, H=3, M=8, trigger every 50 idle cycles
    logic       rstn_c = 1'b0, start_c = 1'b0, rdy_c = 1'b1;
    logic       ld_c, ostb_c, busy_c, done_c;
    logic [5:0] dcnt_c;
    logic [4:0] otap_c;
    logic [7:0] ocnt_c;

    idelay_tap_scheduler #(
        .DELAY_TAPS(4), .COUNT_WIDTH(8), .HOLDOFF_TIME(3), .MEASURE_TIME(8), .TRIGGER_INTERVAL(0)
    ) dut_a (
        .CLK(clk), .RSTN(rstn_a), .START(start_a), .I_STB(i_stb), .I_ERR(i_err),
        .DLY_LD(ld_a), .DLY_CNT(dcnt_a), .O_STB(ostb_a), .O_RDY(rdy_a),
        .O_TAP(otap_a), .O_CNT(ocnt_a), .BUSY(busy_a), .DONE(done_a)
    );

    idelay_tap_scheduler #(
        .DELAY_TAPS(2), .COUNT_WIDTH(3), .HOLDOFF_TIME(3), .MEASURE_TIME(20), .TRIGGER_INTERVAL(0)
    ) dut_b (
        .CLK(clk), .RSTN(rstn_b), .START(start_b), .I_STB(i_stb), .I_ERR(i_err),
        .DLY_LD(ld_b), .DLY_CNT(dcnt_b), .O_STB(ostb_b), .O_RDY(rdy_b),
        .O_TAP(otap_b), .O_CNT(ocnt_b), .BUSY(busy_b), .DONE(done_b)
    );

    idelay_tap_scheduler #(
        .DELAY_TAPS(2), .COUNT_WIDTH(8), .HOLDOFF_TIME(3), .MEASURE_TIME(8), .TRIGGER_INTERVAL(50)
    ) dut_c (
        .CLK(clk), .RSTN(rstn_c), .START(start_c), .I_STB(i_stb), .I_ERR(i_err),
        .DLY_LD(ld_c), .DLY_CNT(dcnt_c), .O_STB(ostb_c), .O_RDY(rdy_c),
        .O_TAP(otap_c), .O_CNT(ocnt_c), .BUSY(busy_c), .DONE(done_c)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_rst_a();
        check("rst_ld",   32'(ld_a),   0);
        check("rst_dcnt", 32'(dcnt_a), 0);
        check("rst_stb",  32'(ostb_a), 0);
        check("rst_tap",  32'(otap_a), 0);
        check("rst_cnt",  32'(ocnt_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
    endtask

    // Full 4-tap sweep on DUT A. err_mode: 0 none, 1 always, 2 only around HOLDOFF.
    // stall_tap: tap whose REPORT is held 5 extra cycles (-1 for none).
    task automatic sweep_a(input int err_mode, input int stall_tap, input int start_mid);
        int cyc, n_ld, last_ld, err_hold, done_cyc, last_stb, exp_cnt, extra_ld;
        int stb_n[4];
        cyc = 0; n_ld = 0; last_ld = 0; err_hold = 0; done_cyc = -1; last_stb = -100;
        extra_ld = 0;
        for (int t = 0; t < 4; t++) stb_n[t] = 0;
        exp_cnt = (err_mode == 1) ? 8 : 0;
        @(negedge clk);
        start_a = 1'b1;
        rdy_a   = 1'b1;
        i_stb   = (err_mode == 1);
        i_err   = (err_mode == 1);
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (cyc < 300 && done_cyc < 0) begin
            if (ld_a) begin
                check("ld_tap", 32'(dcnt_a), n_ld);
                if (n_ld > 0)
                    check("ld_gap", cyc - last_ld, (n_ld - 1 == stall_tap) ? 18 : 13);
                last_ld = cyc;
                n_ld++;
                if (err_mode == 2) err_hold = 4;
            end
            if (ostb_a) begin
                check("o_tap", 32'(otap_a), n_ld - 1);
                check("o_cnt", 32'(ocnt_a), exp_cnt);
                if (n_ld >= 1 && n_ld <= 4) stb_n[n_ld-1]++;
                last_stb = cyc;
            end
            if (done_a) begin
                done_cyc = cyc;
                check("stb_at_done", 32'(ostb_a), 0);
            end
            if (err_mode == 2) begin
                i_stb = (err_hold > 0);
                i_err = (err_hold > 0);
                if (err_hold > 0) err_hold--;
            end
            rdy_a = 1'b1;
            if (ostb_a && (n_ld - 1 == stall_tap) && n_ld >= 1 && n_ld <= 4 && stb_n[n_ld-1] <= 5)
                rdy_a = 1'b0;
            if (start_mid != 0 && cyc == 20) start_a = 1'b1;
            if (start_mid != 0 && cyc == 21) start_a = 1'b0;
            @(negedge clk);
            cyc++;
        end
        i_stb = 1'b0;
        i_err = 1'b0;
        rdy_a = 1'b1;
        check("done_pos", done_cyc, last_stb + 1);
        check("ld_count", n_ld, 4);
        for (int t = 0; t < 4; t++)
            check("stb_cycles", stb_n[t], (t == stall_tap) ? 6 : 1);
        check("busy_after", 32'(busy_a), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ld_a) extra_ld++;
        end
        check("no_requeue", extra_ld, 0);
    endtask

    initial begin
        int k, n_stb, done_k, n_ld;
        int lds[$];
        int busy60, busy100;

        repeat (3) @(negedge clk);
        check_rst_a();
        rstn_a = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_a), 0);

        sweep_a(0, -1, 0);      // basic sweep, spacing 13
        sweep_a(1, -1, 0);      // errors every cycle -> 8 per tap
        sweep_a(2, -1, 1);      // errors only in HOLDOFF -> 0; START mid-sweep ignored
        sweep_a(0, 1, 0);       // tap 1 REPORT stalled 5 cycles

        // Reset during MEASURE of tap 2
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (k < 200 && !(ld_a && dcnt_a == 6'd2)) begin
            @(negedge clk);
            k++;
        end
        check("tap2_reached", 32'(k < 200), 1);
        repeat (5) @(negedge clk);
        check("in_measure_busy", 32'(busy_a), 1);
        rstn_a = 1'b0;
        @(negedge clk);
        check_rst_a();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_stb", 32'(ostb_a), 0);
        end
        rstn_a = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(ostb_a | done_a | ld_a), 0);
        end
        sweep_a(0, -1, 0);      // resumes from tap 0

        // Saturation on a 3-bit counter
        rstn_b = 1'b1;
        i_stb  = 1'b1;
        i_err  = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0; n_stb = 0; done_k = -1;
        while (k < 200 && done_k < 0) begin
            if (ostb_b) begin
                check("sat_cnt", 32'(ocnt_b), 7);
                n_stb++;
            end
            if (done_b) done_k = k;
            @(negedge clk);
            k++;
        end
        check("sat_done_seen", 32'(done_k >= 0), 1);
        check("sat_stb_count", n_stb, 2);
        i_stb = 1'b0;
        i_err = 1'b0;

        // Auto-trigger 50 cycles after reset release; START while busy ignored
        rstn_c = 1'b1;
        k = 0; done_k = -1; busy60 = -1; busy100 = -1;
        while (k < 130) begin
            @(negedge clk);
            k++;
            if (ld_c) lds.push_back(k);
            if (done_c && done_k < 0) done_k = k;
            if (k == 60) busy60 = int'(busy_c);
            if (k == 100) busy100 = int'(busy_c);
            if (k == 55) start_c = 1'b1;
            if (k == 56) start_c = 1'b0;
        end
        n_ld = lds.size();
        check("trig_ld_count", n_ld, 3);
        if (n_ld >= 1) check("trig_first_ld", lds[0], 50);
        if (n_ld >= 2) check("trig_second_ld", lds[1], 63);
        if (n_ld >= 3) check("trig_rearm_ld", lds[2], 126);
        check("trig_done", done_k, 76);
        check("trig_busy60", busy60, 1);
        check("trig_busy100", busy100, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_idelay_tap_scheduler
`default_nettype wire

// File: doc/idelay_tap_scheduler.md
IDELAY_TAP_SCHEDULER -- requirements
Module: idelay_tap_scheduler

Interface
REQ-001 SHALL have parameter DELAY_TAPS, default 32: number of taps swept, range 2..32.
REQ-002 SHALL have parameter COUNT_WIDTH, default 24: error count width.
REQ-003 SHALL have parameter HOLDOFF_TIME, default 100: settle cycles after each tap load, minimum 1.
REQ-004 SHALL have parameter MEASURE_TIME, default 10000: measurement window in cycles, minimum 1.
REQ-005 SHALL have parameter TRIGGER_INTERVAL, default 50000000: auto-restart period in cycles; 0 disables auto-restart.
REQ-006 SHALL have port CLK, input, 1: the single clock.
REQ-007 SHALL have port RSTN, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port START, input, 1: sweep request pulse.
REQ-009 SHALL have port I_STB, input, 1: comparator sample valid.
REQ-010 SHALL have port I_ERR, input, 1: comparator mismatch, qualified by I_STB.
REQ-011 SHALL have port DLY_LD, output, 1: IDELAY VAR_LOAD strobe.
REQ-012 SHALL have port DLY_CNT, output, 6: IDELAY tap value, with the upper bit always 0.
REQ-013 SHALL have port O_STB, output, 1: result valid.
REQ-014 SHALL have port O_RDY, input, 1: result accepted.
REQ-015 SHALL have port O_TAP, output, 5: tap index of the result.
REQ-016 SHALL have port O_CNT, output, COUNT_WIDTH: error count of the result.
REQ-017 SHALL have port BUSY, output, 1: sweep in progress.
REQ-018 SHALL have port DONE, output, 1: one-cycle pulse at sweep end.

Function
REQ-019 SHALL implement an FSM with states IDLE, LOAD, HOLDOFF, MEASURE, REPORT.
REQ-020 SHALL, in IDLE, go to LOAD with tap=0 on START=1, or on trigger-timer expiry when TRIGGER_INTERVAL>0.
REQ-021 SHALL run the trigger timer only in IDLE, and reload it to TRIGGER_INTERVAL-1 on leaving IDLE.
REQ-022 SHALL, in LOAD, assert DLY_LD for exactly one cycle with DLY_CNT=tap, then enter HOLDOFF.
REQ-023 SHALL hold DLY_CNT at the current tap in every state from LOAD through REPORT.
REQ-024 SHALL remain in HOLDOFF for exactly HOLDOFF_TIME cycles and ignore I_STB/I_ERR there.
REQ-025 SHALL clear the error count on HOLDOFF exit.
REQ-026 SHALL remain in MEASURE for exactly MEASURE_TIME cycles.
REQ-027 SHALL, in MEASURE, increment the count by 1 on each cycle with I_STB=1 and I_ERR=1, saturating at all-ones with no wrap.
REQ-028 SHALL, in REPORT, drive O_STB=1 with stable O_TAP and O_CNT until a cycle with O_RDY=1.
REQ-029 SHALL allow O_RDY=1 on the first REPORT cycle, giving a one-cycle result.
REQ-030 SHALL, on acceptance with tap<DELAY_TAPS-1, increment tap and go to LOAD.
REQ-031 SHALL, on acceptance with tap=DELAY_TAPS-1, go to IDLE and pulse DONE on the same cycle O_STB falls.
REQ-032 SHALL set BUSY=1 in every state except IDLE.
REQ-033 SHALL ignore START while BUSY, with no queuing.
REQ-034 SHALL give START priority over trigger-timer expiry when both occur in the same IDLE cycle; a single sweep starts.
REQ-035 SHALL make each tap take exactly 1+HOLDOFF_TIME+MEASURE_TIME+R cycles, where R≥1 is the number of REPORT cycles.

Reset
REQ-036 SHALL, while RSTN=0 at a clock edge, force state=IDLE, tap=0, count=0, and the trigger timer to TRIGGER_INTERVAL-1.
REQ-037 SHALL, under reset, drive DLY_LD=0, DLY_CNT=0, O_STB=0, O_TAP=0, O_CNT=0, BUSY=0, DONE=0.
REQ-038 SHALL abandon any sweep when reset is asserted mid-sweep, emitting no further O_STB or DONE.

Structure
REQ-039 SHALL place the FSM state encoding and the tap-width constant (5) in a shared package, idelay_pkg.
REQ-040 SHALL implement the HOLDOFF/MEASURE/trigger down-counters as one reusable sub-module, cycle_timer (load, decrement, zero flag).

Verification
REQ-041 SHALL cover: DELAY_TAPS=4, HOLDOFF_TIME=3, MEASURE_TIME=8, O_RDY=1, START pulse -> 4 DLY_LD pulses with DLY_CNT 0,1,2,3 spaced 13 cycles, and DONE one cycle after the 4th O_STB.
REQ-042 SHALL cover: I_STB=I_ERR=1 every cycle with MEASURE_TIME=8 -> O_CNT=8 for every tap; errors driven only in HOLDOFF -> O_CNT=0.
REQ-043 SHALL cover: COUNT_WIDTH=3, MEASURE_TIME=20, constant errors -> O_CNT=7, saturated.
REQ-044 SHALL cover: O_RDY held 0 for 5 cycles in REPORT -> O_STB high 6 cycles with O_TAP/O_CNT unchanged and the next DLY_LD delayed accordingly.
REQ-045 SHALL cover: TRIGGER_INTERVAL=50, no START -> a sweep begins 50 cycles after reset release; START during BUSY is ignored.
REQ-046 SHALL cover: RSTN=0 during MEASURE of tap 2 -> next cycle shows all outputs at reset values; a later START resumes from tap 0.
